stopwatch_counter: RTL and testbench

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

---
 rtl/stopwatch_counter_pkg.sv | 30 +++
 rtl/stopwatch_counter_btn_debounce.sv | 45 ++++
 rtl/stopwatch_counter.sv | 87 ++++++++
 tb/tb_stopwatch_counter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_counter_pkg.sv
// Shared types, digit limits and BCD helpers for the MM:SS stopwatch.
package stopwatch_counter_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        PAUSED = 1'b1
    } sw_state_t;

    localparam int ONES_MAX           = 9;
    localparam int TENS_MAX           = 5;
    localparam int DEB_CYCLES_DEFAULT = 500000;

    // Two-digit 00-59 increment with wrap; out-of-range digits fold back to zero.
    function automatic logic [6:0] bcd_inc(input logic [2:0] tens, input logic [3:0] ones);
        logic [2:0] t;
        logic [3:0] o;
        t = tens;
        o = ones + 4'd1;
        if (ones >= 4'(ONES_MAX)) begin
            o = 4'd0;
            t = (tens >= 3'(TENS_MAX)) ? 3'd0 : tens + 3'd1;
        end
        return {t, o};
    endfunction

    function automatic logic bcd_wraps(input logic [2:0] tens, input logic [3:0] ones);
        return (ones >= 4'(ONES_MAX)) && (tens >= 3'(TENS_MAX));
    endfunction

endpackage

// File: rtl/stopwatch_counter_btn_debounce.sv
// Raw push-button to one-cycle press pulse: 2-flop synchronizer, stability
// counter, rising-edge detect on the debounced level.
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // NOTE: every flop here is reset so a press pending at reset is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // DEB_CYCLES consecutive differing samples: accept the new level.
                level <= sync_b;
                press <= sync_b;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch with run/pause FSM, debounced pause/clear buttons and
// a two-field adjust mode driven by the 2 Hz tick.
module stopwatch_counter
    import stopwatch_counter_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       adj,
    input  logic       sel,
    input  logic       pause_btn,
    input  logic       clr_btn,
    output logic [2:0] m10,
    output logic [3:0] m1,
    output logic [2:0] s10,
    output logic [3:0] s1,
    output logic       paused
);

    logic       pause_press;
    logic       clr_press;
    sw_state_t  state;
    sw_state_t  state_next;
    logic [6:0] sec_d;
    logic [6:0] min_d;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_pause_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (pause_btn),
        .press (pause_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (clr_btn),
        .press (clr_press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_next;
    end

    // NOTE: defaults first so no path through this block can infer a latch.
    always_comb begin
        state_next = state;
        if (pause_press) state_next = (state == RUN) ? PAUSED : RUN;
    end

    assign paused = (state == PAUSED);

    // Clear beats adjust beats counting; adjust never carries between fields.
    always_comb begin
        sec_d = {s10, s1};
        min_d = {m10, m1};
        if (clr_press) begin
            sec_d = '0;
            min_d = '0;
        end else if (adj) begin
            if (tick_2hz) begin
                if (sel) sec_d = bcd_inc(s10, s1);
                else     min_d = bcd_inc(m10, m1);
            end
        end else if (state == RUN && tick_1hz) begin
            sec_d = bcd_inc(s10, s1);
            if (bcd_wraps(s10, s1)) min_d = bcd_inc(m10, m1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m10 <= '0;
            m1  <= '0;
            s10 <= '0;
            s1  <= '0;
        end else begin
            {m10, m1} <= min_d;
            {s10, s1} <= sec_d;
        end
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with DEB_CYCLES=4; time is compared as
// the decimal number MMSS built from the four BCD digits.
module tb_stopwatch_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1hz, tick_2hz, adj, sel, pause_btn, clr_btn;
    logic [2:0] m10, s10;
    logic [3:0] m1, s1;
    logic       paused;

    int n_tests = 0;
    int n_fail  = 0;

    stopwatch_counter #(.DEB_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1hz  (tick_1hz),
        .tick_2hz  (tick_2hz),
        .adj       (adj),
        .sel       (sel),
        .pause_btn (pause_btn),
        .clr_btn   (clr_btn),
        .m10       (m10),
        .m1        (m1),
        .s10       (s10),
        .s1        (s1),
        .paused    (paused)
    );

    always #5 clk = ~clk;

    function automatic int time_val();
        return int'(m10) * 1000 + int'(m1) * 100 + int'(s10) * 10 + int'(s1);
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick1(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1;
            @(negedge clk);
        end
        tick_1hz = 1'b0;
    endtask

    task automatic tick2(input int n);
        for (int i = 0; i < n; i++) begin
            tick_2hz = 1'b1;
            @(negedge clk);
        end
        tick_2hz = 1'b0;
    endtask

    task automatic press(input logic p, input logic c, input int hold);
        pause_btn = p;
        clr_btn   = c;
        repeat (hold) @(negedge clk);
        pause_btn = 1'b0;
        clr_btn   = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        {tick_1hz, tick_2hz, adj, sel, pause_btn, clr_btn} = '0;
        #12;
        check("reset_time", time_val(), 0);
        check("reset_paused", int'(paused), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 00:59 -> 01:00
        adj = 1'b1; sel = 1'b1;
        tick2(59);
        check("adj_sec_59", time_val(), 59);
        adj = 1'b0;
        tick1(1);
        check("carry_0059", time_val(), 100);

        // 59:59 -> 00:00
        adj = 1'b1; sel = 1'b0;
        tick2(58);
        sel = 1'b1;
        tick2(59);
        check("adj_5959", time_val(), 5959);
        adj = 1'b0;
        tick1(1);
        check("wrap_5959", time_val(), 0);

        // Held pause button toggles exactly once; paused holds digits
        press(1'b1, 1'b0, 20);
        check("pause_held", int'(paused), 1);
        tick1(3);
        check("paused_hold", time_val(), 0);
        check("paused_still", int'(paused), 1);
        press(1'b1, 1'b0, 10);
        check("unpause", int'(paused), 0);

        // 2-cycle glitches never reach DEB_CYCLES stable samples
        for (int i = 0; i < 5; i++) begin
            pause_btn = 1'b1;
            repeat (2) @(negedge clk);
            pause_btn = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("glitch_no_toggle", int'(paused), 0);

        // Adjust: 07:58 + three 2 Hz ticks on seconds -> 07:01, no carry
        adj = 1'b1; sel = 1'b0;
        tick2(7);
        sel = 1'b1;
        tick2(58);
        check("adj_0758", time_val(), 758);
        tick2(3);
        check("adj_wrap_0701", time_val(), 701);
        tick1(2);
        check("adj_ignores_1hz", time_val(), 701);
        adj = 1'b0;
        tick_1hz = 1'b1; tick_2hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0; tick_2hz = 1'b0;
        check("both_ticks_one_sec", time_val(), 702);

        // 12:34, then clear pulse lands in the same cycle as a 1 Hz tick
        adj = 1'b1; sel = 1'b0;
        tick2(5);
        sel = 1'b1;
        tick2(32);
        adj = 1'b0;
        check("preset_1234", time_val(), 1234);
        clr_btn = 1'b1;
        repeat (6) @(negedge clk);
        check("before_clear", time_val(), 1234);
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        check("clear_beats_tick", time_val(), 0);
        clr_btn = 1'b0;
        repeat (10) @(negedge clk);
        check("clear_keeps_run", int'(paused), 0);

        // Simultaneous clear and pause both act
        tick1(3);
        check("run_after_clear", time_val(), 3);
        press(1'b1, 1'b1, 10);
        check("clr_pause_time", time_val(), 0);
        check("clr_pause_state", int'(paused), 1);

        // Async reset in the middle of an adjust burst
        adj = 1'b1; sel = 1'b1;
        tick2(5);
        check("adj_while_paused", time_val(), 5);
        tick_2hz = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_time", time_val(), 0);
        check("async_rst_paused", int'(paused), 0);
        @(negedge clk);
        tick_2hz = 1'b0; adj = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-debounce discards the pending press
        pause_btn = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        pause_btn = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_discards_press", int'(paused), 0);
        tick1(1);
        check("count_after_rst", time_val(), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
